timer_scheduler: RTL and testbench

//   Shares one CW-bit elapsed-cycle counter among NREQ requesters. Each requester asks for a

---
 rtl/timer_scheduler.sv | 146 ++++++++++++++
 tb/tb_timer_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// Round-robin arbiter sharing one elapsed-cycle counter among NREQ requesters.
// Optional abort/aborted ports are enabled by defining TIMER_SCHED_ABORT_EN.
module timer_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] req_len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [CW-1:0]     count
`ifdef TIMER_SCHED_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  logic [PW-1:0]  owner;
  logic [PW-1:0]  rr_ptr;
  logic [CW-1:0]  len_lat;
  logic [CW-1:0]  lens [NREQ];
  logic [PW-1:0]  pick;
  logic [PW-1:0]  owner_next;
  logic           abort_hit;

`ifdef TIMER_SCHED_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lens[i] = req_len[i*CW +: CW];
    end
  end

  // First pending request at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign owner_next = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      count   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      len_lat <= '0;
`ifdef TIMER_SCHED_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      grant <= '0;
      done  <= '0;
`ifdef TIMER_SCHED_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            owner   <= pick;
            len_lat <= lens[pick];
            grant   <= NREQ'(1) << pick;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          count  <= '0;
          rr_ptr <= owner_next;
          if (abort_hit || len_lat == '0) begin
            done  <= NREQ'(1) << owner;
`ifdef TIMER_SCHED_ABORT_EN
            aborted <= abort_hit;
`endif
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          // An abort freezes count at its current value.
          if (abort_hit) begin
            done  <= NREQ'(1) << owner;
`ifdef TIMER_SCHED_ABORT_EN
            aborted <= 1'b1;
`endif
            state <= DONE;
          end else begin
            count <= count + CW'(1);
            if (count == len_lat - CW'(1)) begin
              done  <= NREQ'(1) << owner;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with NREQ=4, CW=8.
module tb_timer_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] req_len;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [CW-1:0]     count;
`ifdef TIMER_SCHED_ABORT_EN
  logic              abort;
  logic              aborted;
`endif

  int total = 0;
  int bad   = 0;

  timer_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .count   (count)
`ifdef TIMER_SCHED_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_len(input int idx, input logic [CW-1:0] v);
    req_len[idx*CW +: CW] = v;
  endtask

  logic [NREQ-1:0] exp_g [6];

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    req     = '0;
    req_len = '0;
`ifdef TIMER_SCHED_ABORT_EN
    abort   = 1'b0;
`endif
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_count", 32'(count), 32'h0);
    rst = 1'b0;

    // Test 1: single request, len=5, req dropped and len changed after grant.
    req = 4'b0010;
    set_len(1, 8'd5);
    tick();
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_busy1", 32'(busy),  32'h1);
    req = 4'b0000;
    set_len(1, 8'd99);
    tick();
    chk("t1_grant_off", 32'(grant), 32'h0);
    chk("t1_count_c2",  32'(count), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_count_c6", 32'(count), 32'h4);
    chk("t1_nodone_c6", 32'(done), 32'h0);
    tick();
    chk("t1_done",     32'(done),  32'h2);
    chk("t1_count_c7", 32'(count), 32'h5);
    chk("t1_busy_c7",  32'(busy),  32'h1);
    tick();
    chk("t1_busy_c8",  32'(busy),  32'h0);
    chk("t1_done_c8",  32'(done),  32'h0);
    chk("t1_count_c8", 32'(count), 32'h5);

    // Test 2: round-robin among requesters 0,1,3 with len=1.
    do_reset();
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
    exp_g[3] = 4'b0001; exp_g[4] = 4'b0010; exp_g[5] = 4'b1000;
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t2_grant%0d", k), 32'(grant), 32'(exp_g[k]));
      tick();
      tick();
      chk($sformatf("t2_done%0d", k), 32'(done), 32'(exp_g[k]));
      chk($sformatf("t2_count%0d", k), 32'(count), 32'h1);
      tick();
    end
    req = 4'b0000;

    // Test 3: zero length goes LOAD -> DONE directly.
    do_reset();
    req = 4'b0100;
    req_len = '0;
    tick();
    chk("t3_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    tick();
    chk("t3_done",  32'(done),  32'h4);
    chk("t3_count", 32'(count), 32'h0);
    tick();
    chk("t3_busy",  32'(busy),  32'h0);
    chk("t3_done_off", 32'(done), 32'h0);

    // Test 4: asynchronous reset mid-job, then a fresh job.
    do_reset();
    req = 4'b0001;
    set_len(0, 8'd20);
    tick();
    chk("t4_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_count7", 32'(count), 32'h7);
    rst = 1'b1;
    #1;
    chk("t4_rst_busy",  32'(busy),  32'h0);
    chk("t4_rst_count", 32'(count), 32'h0);
    chk("t4_rst_done",  32'(done),  32'h0);
    chk("t4_rst_grant", 32'(grant), 32'h0);
    tick();
    chk("t4_rst_done2", 32'(done), 32'h0);
    rst = 1'b0;
    req = 4'b0010;
    req_len = '0;
    set_len(1, 8'd2);
    tick();
    chk("t4_new_grant", 32'(grant), 32'h2);
    tick();
    tick();
    chk("t4_new_count1", 32'(count), 32'h1);
    req = 4'b0000;
    tick();
    chk("t4_new_done",  32'(done),  32'h2);
    chk("t4_new_count", 32'(count), 32'h2);
    tick();

`ifdef TIMER_SCHED_ABORT_EN
    // Test 5: abort while count=3.
    do_reset();
    req = 4'b0001;
    req_len = '0;
    set_len(0, 8'd10);
    tick();
    chk("t5_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_count3", 32'(count), 32'h3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_done",    32'(done),    32'h1);
    chk("t5_aborted", 32'(aborted), 32'h1);
    chk("t5_count",   32'(count),   32'h3);
    tick();
    chk("t5_busy",     32'(busy),    32'h0);
    chk("t5_abort_off", 32'(aborted), 32'h0);
`endif

    // Test 6: maximum length 255 without wrap.
    do_reset();
    req = 4'b1000;
    req_len = '0;
    set_len(3, 8'd255);
    tick();
    chk("t6_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    for (int i = 0; i < 255; i++) tick();
    chk("t6_count254", 32'(count), 32'hfe);
    chk("t6_nodone",   32'(done),  32'h0);
    tick();
    chk("t6_done",  32'(done),  32'h8);
    chk("t6_count", 32'(count), 32'hff);
    tick();
    chk("t6_hold",  32'(count), 32'hff);
    chk("t6_busy",  32'(busy),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
